// File: rtl/regfile_write_buffer_pkg.sv
// Shared register-file definitions for the writeback buffer: widths, the zero
// register index and the writeback entry layout.
package regfile_write_buffer_pkg;
  localparam int REG_ADDR_W = 5;
  localparam int WORD_W     = 32;
  localparam int REG_ZERO   = 0;

  typedef struct packed {
    logic [REG_ADDR_W-1:0] rd;
    logic [WORD_W-1:0]     data;
  } wb_entry_t;
endpackage

// File: rtl/regfile_write_buffer_wb_fifo.sv
// Circular storage for queued writebacks: entry arrays, read/write pointers
// and occupancy count. The caller guarantees no push when full, no pop when empty.
module regfile_write_buffer_wb_fifo #(
  parameter int DEPTH  = 4,
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
) (
  input  logic                           clk_i,
  input  logic                           rst_i,
  input  logic                           push_i,
  input  logic                           pop_i,
  input  logic [ADDR_W-1:0]              reg_i,
  input  logic [DATA_W-1:0]              data_i,
  output logic [ADDR_W-1:0]              head_reg_o,
  output logic [DATA_W-1:0]              head_data_o,
  output logic [$clog2(DEPTH):0]         count_o,
  output logic [$clog2(DEPTH)-1:0]       rd_ptr_o,
  output logic [DEPTH-1:0][ADDR_W-1:0]   regs_o,
  output logic [DEPTH-1:0][DATA_W-1:0]   datas_o
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [PTR_W-1:0]              wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]              rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]              count_q, count_d;
  logic [DEPTH-1:0][ADDR_W-1:0]  regs_q;
  logic [DEPTH-1:0][DATA_W-1:0]  datas_q;

  // Pointers wrap naturally because DEPTH is a power of two.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_i) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (pop_i)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
    case ({push_i, pop_i})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push_i) begin
      regs_q[wr_ptr_q]  <= reg_i;
      datas_q[wr_ptr_q] <= data_i;
    end
  end

  assign head_reg_o  = regs_q[rd_ptr_q];
  assign head_data_o = datas_q[rd_ptr_q];
  assign count_o     = count_q;
  assign rd_ptr_o    = rd_ptr_q;
  assign regs_o      = regs_q;
  assign datas_o     = datas_q;
endmodule

// File: rtl/regfile_write_buffer.sv
// Writeback queue in front of the register file's single write port.
// Define REGFILE_WRITE_BUFFER_FWD_EN to let ID forward from pending writes.
module regfile_write_buffer
  import regfile_write_buffer_pkg::*;
#(
  parameter int DEPTH  = 4,
  parameter int DATA_W = WORD_W,
  parameter int ADDR_W = REG_ADDR_W
) (
  input  logic                   Clk,
  input  logic                   Reset,
  input  logic                   InValid,
  output logic                   InReady,
  input  logic [ADDR_W-1:0]      InReg,
  input  logic [DATA_W-1:0]      InData,
  output logic [ADDR_W-1:0]      WriteRegister,
  output logic [DATA_W-1:0]      WriteData,
  output logic                   RegWrite,
  output logic [$clog2(DEPTH):0] Count,
  input  logic [ADDR_W-1:0]      LookupReg1,
  input  logic [ADDR_W-1:0]      LookupReg2,
  output logic                   FwdHit1,
  output logic                   FwdHit2,
  output logic [DATA_W-1:0]      FwdData1,
  output logic [DATA_W-1:0]      FwdData2
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic                          push, pop;
  logic [ADDR_W-1:0]             head_reg;
  logic [DATA_W-1:0]             head_data;
  logic [CNT_W-1:0]              count;
  logic [PTR_W-1:0]              rd_ptr;
  logic [DEPTH-1:0][ADDR_W-1:0]  fifo_regs;
  logic [DEPTH-1:0][DATA_W-1:0]  fifo_datas;
  logic                          regwrite_q;
  logic [ADDR_W-1:0]             wr_reg_q;
  logic [DATA_W-1:0]             wr_data_q;

  // Writes to r0 are consumed here so they never occupy a slot or a port cycle.
  assign InReady = (count < CNT_W'(DEPTH));
  assign push    = InValid && InReady && (InReg != ADDR_W'(REG_ZERO));
  assign pop     = (count != '0);

  regfile_write_buffer_wb_fifo #(
    .DEPTH (DEPTH),
    .DATA_W(DATA_W),
    .ADDR_W(ADDR_W)
  ) u_fifo (
    .clk_i      (Clk),
    .rst_i      (Reset),
    .push_i     (push),
    .pop_i      (pop),
    .reg_i      (InReg),
    .data_i     (InData),
    .head_reg_o (head_reg),
    .head_data_o(head_data),
    .count_o    (count),
    .rd_ptr_o   (rd_ptr),
    .regs_o     (fifo_regs),
    .datas_o    (fifo_datas)
  );

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      regwrite_q <= 1'b0;
      wr_reg_q   <= '0;
      wr_data_q  <= '0;
    end else begin
      regwrite_q <= pop;
      if (pop) begin
        wr_reg_q  <= head_reg;
        wr_data_q <= head_data;
      end
    end
  end

  assign RegWrite      = regwrite_q;
  assign WriteRegister = wr_reg_q;
  assign WriteData     = wr_data_q;
  assign Count         = count;

`ifdef REGFILE_WRITE_BUFFER_FWD_EN
  // Scan oldest-to-youngest so the youngest match overrides; the output stage
  // is checked first because it is older than anything still queued.
  function automatic logic [DATA_W:0] fwd_search(
    input logic [ADDR_W-1:0]             lk,
    input logic                          out_vld,
    input logic [ADDR_W-1:0]             out_reg,
    input logic [DATA_W-1:0]             out_data,
    input logic [CNT_W-1:0]              cnt,
    input logic [PTR_W-1:0]              rptr,
    input logic [DEPTH-1:0][ADDR_W-1:0]  regs,
    input logic [DEPTH-1:0][DATA_W-1:0]  datas
  );
    logic [DATA_W:0]  res;
    logic [PTR_W-1:0] idx;
    res = '0;
    if (out_vld && (out_reg == lk)) res = {1'b1, out_data};
    for (int i = 0; i < DEPTH; i++) begin
      idx = rptr + PTR_W'(i);
      if ((CNT_W'(i) < cnt) && (regs[idx] == lk)) res = {1'b1, datas[idx]};
    end
    if (lk == ADDR_W'(REG_ZERO)) res = '0;
    return res;
  endfunction

  assign {FwdHit1, FwdData1} = fwd_search(LookupReg1, regwrite_q, wr_reg_q, wr_data_q,
                                          count, rd_ptr, fifo_regs, fifo_datas);
  assign {FwdHit2, FwdData2} = fwd_search(LookupReg2, regwrite_q, wr_reg_q, wr_data_q,
                                          count, rd_ptr, fifo_regs, fifo_datas);
`else
  logic unused_fwd;
  assign unused_fwd = ^{LookupReg1, LookupReg2, rd_ptr, fifo_regs, fifo_datas};
  assign FwdHit1  = 1'b0;
  assign FwdHit2  = 1'b0;
  assign FwdData1 = '0;
  assign FwdData2 = '0;
`endif
endmodule
